// File: rtl/mdu_if.sv
// Operand, control and result bundle between the CPU datapath and the mdu.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, hi_we, lo_we, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, hi_we, lo_we, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One bit per clock on unsigned magnitudes; signs are applied in a final fix-up cycle.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   mag_a_reg, mag_a_next;
    logic [WIDTH-1:0]   mag_b_reg, mag_b_next;
    logic               is_div_reg, is_div_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, dividend_fix;

    // op[0] set means unsigned: operands are taken raw
    assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_a_reg} : {(WIDTH+1){1'b0}});

    // Restoring step: partial remainder in the high half, dividend shifts out of the low half
    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_fit   = div_shift >= {1'b0, mag_b_reg};
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b_reg;
    assign rem_new   = div_fit ? div_diff : div_shift[WIDTH-1:0];

    assign prod_fix     = neg_q_reg ? -acc_reg : acc_reg;
    assign quo_fix      = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix      = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    assign dividend_fix = neg_r_reg ? -mag_a_reg : mag_a_reg;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        mag_a_next  = mag_a_reg;
        mag_b_next  = mag_b_reg;
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next  = RUN;
                    count_next  = LAST;
                    mag_a_next  = a_mag;
                    mag_b_next  = b_mag;
                    is_div_next = bus.op[1];
                    neg_q_next  = a_neg ^ b_neg;
                    neg_r_next  = a_neg;
                    acc_next    = bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                end else begin
                    if (bus.hi_we) hi_next = bus.a;
                    if (bus.lo_we) lo_next = bus.a;
                end
            end
            RUN: begin
                if (is_div_reg) acc_next = {rem_new, acc_reg[WIDTH-2:0], div_fit};
                else            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
                if (count_reg == '0) state_next = FIX;
                else                 count_next = count_reg - 1'b1;
            end
            FIX: begin
                state_next = IDLE;
                done_next  = 1'b1;
                if (!is_div_reg) begin
                    {hi_next, lo_next} = prod_fix;
                end else if (mag_b_reg == '0) begin
                    // Divide by zero: quotient saturates, dividend passes through as remainder
                    lo_next = '1;
                    hi_next = dividend_fix;
                end else begin
                    lo_next = quo_fix;
                    hi_next = rem_fix;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            mag_a_reg  <= mag_a_next;
            mag_b_reg  <= mag_b_next;
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule
